// File: rtl/amber_uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | amber_uart_pkg : shared UART types, constants and baud helper        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package amber_uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam int DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : single-clock show-ahead FIFO with wrap-bit pointers      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int            c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0] c_PTR_ONE = (c_AW + 1)'(1);

    logic [c_AW:0]      r_wr;
    logic [c_AW:0]      r_rd;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_pop;
    logic               w_push;

    // A push into a full FIFO is accepted when the head leaves on the same edge.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[c_AW] != r_rd[c_AW]) && (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]);
    assign o_data  = r_mem[r_rd[c_AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + c_PTR_ONE;
            if (w_pop)  r_rd <= r_rd + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[c_AW-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_fifo : 8N1 UART receiver feeding a show-ahead byte FIFO      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_rx_fifo
    import amber_uart_pkg::*;
#(
    parameter int CLK_HZ = 12_000_000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overflow,
    input  logic       clr_err,
    output logic       busy
);
    localparam int                 c_CLKS     = clks_per_bit(CLK_HZ, BAUD);
    localparam int                 c_CNT_W    = $clog2(c_CLKS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(c_CLKS);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(c_CLKS / 2);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [2:0]         c_LAST_BIT = 3'(DATA_BITS - 1);

    logic [1:0]           r_sync;
    logic                 r_rxd_d;
    rx_state_t            r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_frame_err;
    logic                 r_overflow;
    logic [DATA_BITS-1:0] r_hold;

    logic                 w_rxd;
    logic                 w_tick;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [DATA_BITS-1:0] w_head;

    assign w_rxd  = r_sync[1];
    assign w_tick = (r_cnt == c_CNT_ONE);
    assign w_push = (r_state == STOP) && w_tick && w_rxd;
    assign w_pop  = rx_ready && !w_empty;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_sync      <= 2'b11;
            r_rxd_d     <= 1'b1;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], rxd};
            r_rxd_d     <= w_rxd;
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_rxd_d && !w_rxd) begin
                        r_state <= START;
                        r_cnt   <= c_CNT_HALF;
                    end
                end
                START: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end else if (w_rxd) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= DATA;
                        r_cnt   <= c_CNT_FULL;
                        r_bit   <= '0;
                    end
                end
                DATA: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end else begin
                        r_shift <= {w_rxd, r_shift[DATA_BITS-1:1]};
                        r_cnt   <= c_CNT_FULL;
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == c_LAST_BIT) r_state <= STOP;
                    end
                end
                STOP: begin
                    // The good-stop push is decoded combinationally into the FIFO.
                    if (!w_tick) begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end else if (w_rxd) begin
                        r_state <= IDLE;
                    end else begin
                        r_frame_err <= 1'b1;
                        r_state     <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (w_rxd) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Overflow set beats a simultaneous clear; r_hold keeps the last head for empty periods.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_hold     <= '0;
        end else begin
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            else if (clr_err)               r_overflow <= 1'b0;
            if (!w_empty) r_hold <= w_head;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (sysclk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (r_shift),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign rx_data   = w_empty ? r_hold : w_head;
    assign rx_valid  = !w_empty;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_rx_fifo : byte-level model bench for uart_rx_fifo            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_rx_fifo;
    localparam int c_BIT = 104;
    localparam int c_LAT = 2 + 52 + 9 * 104 + 1;

    logic       sysclk   = 1'b0;
    logic       rst      = 1'b0;
    logic       rxd      = 1'b1;
    logic       rx_ready = 1'b0;
    logic       clr_err  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overflow;
    logic       busy;

    uart_rx_fifo #(
        .CLK_HZ (12_000_000),
        .BAUD   (115200),
        .DEPTH  (16)
    ) dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overflow  (overflow),
        .clr_err   (clr_err),
        .busy      (busy)
    );

    always #5 sysclk = ~sysclk;

    int         fr_n = 0;
    int         fr_t [128];
    logic [7:0] fr_d [128];
    bit         fr_stop [128];

    int         cyc    = 0;
    logic [7:0] m_q [$];
    bit         m_ovf  = 1'b0;
    bit         m_fe   = 1'b0;
    logic [7:0] m_last = 8'h00;
    int         m_rd   = 0;
    bit         m_push, m_pop, m_drop;
    logic [7:0] m_pd;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] got [$];
    int         fe_cnt = 0;
    int         wd = 0;
    int         base, fe0;
    bit         rdone;
    logic [7:0] rnd_d;
    bit         rnd_st;

    // Byte-level reference: each logged frame lands (or flags) c_LAT edges after its start edge.
    always @(posedge sysclk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_fe   = 1'b0;
            m_last = 8'h00;
            m_rd   = fr_n;
        end else begin
            cyc    = cyc + 1;
            m_push = 1'b0;
            m_fe   = 1'b0;
            m_pd   = 8'h00;
            if (m_rd < fr_n && cyc == fr_t[m_rd] + c_LAT) begin
                m_push = fr_stop[m_rd];
                m_fe   = !fr_stop[m_rd];
                m_pd   = fr_d[m_rd];
                m_rd++;
            end
            if (m_q.size() != 0) m_last = m_q[0];
            m_pop  = rx_ready && (m_q.size() != 0);
            m_drop = m_push && (m_q.size() == 16) && !m_pop;
            if (m_pop) void'(m_q.pop_front());
            if (m_push && !m_drop) m_q.push_back(m_pd);
            if (m_drop) m_ovf = 1'b1;
            else if (clr_err) m_ovf = 1'b0;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int got_at(input int i);
        if (i < got.size()) return int'(got[i]);
        return 32'h100;
    endfunction

    task automatic compare_loop();
        forever begin
            @(negedge sysclk);
            chk("rx_valid", int'(rx_valid), int'(m_q.size() != 0));
            if (m_q.size() != 0) chk("rx_data", int'(rx_data), int'(m_q[0]));
            else                 chk("rx_data_hold", int'(rx_data), int'(m_last));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("frame_err", int'(frame_err), int'(m_fe));
            if (rx_valid && rx_ready) got.push_back(rx_data);
            if (frame_err) fe_cnt++;
            wd++;
            if (wd > 90000) begin
                $display("FAIL watchdog: cycles %0d, limit 90000", wd);
                $fatal(1, "bench timeout");
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    // Drives one 8N1 frame; limit >= 0 abandons it after that many cycles.
    task automatic send_frame(input logic [7:0] d, input bit stop, input int limit);
        logic [9:0] f;
        int         k;
        f = {stop, d, 1'b0};
        fr_t[fr_n]    = cyc;
        fr_d[fr_n]    = d;
        fr_stop[fr_n] = stop;
        fr_n++;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            for (int j = 0; j < c_BIT; j++) begin
                if (k == limit) return;
                tick(1);
                k++;
            end
        end
        rxd = 1'b1;
    endtask

    initial begin
        fork
            compare_loop();
        join_none

        rst = 1'b1;
        tick(3);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        tick(5);

        // back-to-back bytes
        rx_ready = 1'b1;
        base = got.size();
        send_frame(8'h55, 1'b1, -1);
        send_frame(8'hA3, 1'b1, -1);
        tick(20);
        chk("t1_count", got.size() - base, 2);
        chk("t1_byte0", got_at(base), 8'h55);
        chk("t1_byte1", got_at(base + 1), 8'hA3);

        // false start
        fe0 = fe_cnt;
        rxd = 1'b0;
        tick(20);
        chk("t2_busy_start", int'(busy), 1);
        rxd = 1'b1;
        tick(40);
        chk("t2_busy_end", int'(busy), 0);
        tick(10);
        chk("t2_no_frame_err", fe_cnt - fe0, 0);

        // framing error followed by a break, then a good byte
        fe0  = fe_cnt;
        base = got.size();
        send_frame(8'h3C, 1'b0, -1);
        rxd = 1'b0;
        tick(200);
        chk("t3_busy_break", int'(busy), 1);
        rxd = 1'b1;
        tick(20);
        chk("t3_fe_pulses", fe_cnt - fe0, 1);
        chk("t3_no_byte", got.size() - base, 0);
        send_frame(8'h81, 1'b1, -1);
        tick(20);
        chk("t3_byte", got_at(base), 8'h81);

        // overflow on the 17th byte
        rx_ready = 1'b0;
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, -1);
        tick(5);
        chk("t4_overflow", int'(overflow), 1);
        base = got.size();
        rx_ready = 1'b1;
        tick(20);
        rx_ready = 1'b0;
        chk("t4_count", got.size() - base, 16);
        for (int i = 0; i < 16; i++) chk($sformatf("t4_byte%0d", i), got_at(base + i), i);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        tick(1);
        chk("t4_cleared", int'(overflow), 0);

        // reset in the middle of bit 4
        send_frame(8'hA5, 1'b1, -1);
        tick(5);
        send_frame(8'hF0, 1'b1, 5 * c_BIT + c_BIT / 2);
        chk("t5_busy_mid", int'(busy), 1);
        chk("t5_valid_before", int'(rx_valid), 1);
        rst = 1'b1;
        #1;
        chk("t5_rx_valid", int'(rx_valid), 0);
        chk("t5_rx_data", int'(rx_data), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_overflow", int'(overflow), 0);
        tick(3);
        rxd = 1'b1;
        rst = 1'b0;
        tick(5);
        rx_ready = 1'b1;
        base = got.size();
        send_frame(8'h0F, 1'b1, -1);
        tick(20);
        chk("t5_byte", got_at(base), 8'h0F);

        // full FIFO with a pop on the stop-sample edge of byte 17
        rx_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_frame(8'(8'h40 + i), 1'b1, -1);
        base = got.size();
        fork
            send_frame(8'h50, 1'b1, -1);
            begin
                tick(c_LAT - 1);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
            end
        join
        tick(5);
        chk("t6_overflow", int'(overflow), 0);
        rx_ready = 1'b1;
        tick(20);
        rx_ready = 1'b0;
        chk("t6_count", got.size() - base, 17);
        chk("t6_first", got_at(base), 8'h40);
        chk("t6_second", got_at(base + 1), 8'h41);
        chk("t6_last", got_at(base + 16), 8'h50);

        // randomized frames, gaps, back-pressure and clears
        rdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    rnd_d  = 8'($urandom);
                    rnd_st = ($urandom_range(5) != 0);
                    send_frame(rnd_d, rnd_st, -1);
                    tick(rnd_st ? $urandom_range(0, 30) : 10 + $urandom_range(0, 30));
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    rx_ready = 1'($urandom_range(1));
                    clr_err  = ($urandom_range(15) == 0);
                    tick(1);
                end
                clr_err = 1'b0;
            end
        join
        rx_ready = 1'b1;
        tick(40);
        chk("t7_drained", int'(rx_valid), 0);
        chk("t7_idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
